// File: rtl/apb_pair.sv
// APB link: a master front-end that sequences SETUP/ACCESS phases and a
// zero-wait-state 16-word slave register file sharing PSEL and PWRITE.
`timescale 1ns / 1ps

module apb_pair (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        transfer,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PDATA,
  output logic        PENABLE,
  output logic [31:0] PRWADDR,
  output logic [31:0] PRWDATA,
  output logic [31:0] PRDATA1,
  output logic        PREADY
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2
  } state_e;

  state_e      r_state;
  logic        r_penable;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [31:0] r_regs [16];

  logic        w_pready;
  logic        w_in_range;
  logic [3:0]  w_index;
  logic        w_wr_en;
  logic        w_rd_en;

  assign PENABLE = r_penable;
  assign PRWADDR = r_addr;
  assign PRWDATA = r_data;

  // Slave completes every access in the first ACCESS cycle.
  assign w_pready   = PSEL & r_penable;
  assign PREADY     = w_pready;
  assign w_in_range = (r_addr[31:6] == 26'd0);
  assign w_index    = r_addr[5:2];
  assign w_wr_en    = w_pready & PWRITE & w_in_range;
  assign w_rd_en    = w_pready & ~PWRITE & w_in_range;

  // Master FSM; PENABLE is registered alongside the state so it tracks ACCESS exactly.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      r_state   <= StIdle;
      r_penable <= 1'b0;
      r_addr    <= 32'd0;
      r_data    <= 32'd0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (PSEL && transfer) begin
            r_addr  <= PADDR;
            r_data  <= PDATA;
            r_state <= StSetup;
          end
        end
        StSetup: begin
          if (PSEL) begin
            r_state   <= StAccess;
            r_penable <= 1'b1;
          end else begin
            r_state <= StIdle;
          end
        end
        StAccess: begin
          if (!PSEL) begin
            r_state   <= StIdle;
            r_penable <= 1'b0;
          end else if (w_pready && transfer) begin
            r_addr    <= PADDR;
            r_data    <= PDATA;
            r_state   <= StSetup;
            r_penable <= 1'b0;
          end else if (w_pready) begin
            r_state   <= StIdle;
            r_penable <= 1'b0;
          end
        end
        default: begin
          r_state   <= StIdle;
          r_penable <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      for (int i = 0; i < 16; i++) begin
        r_regs[i] <= 32'd0;
      end
    end else if (w_wr_en) begin
      r_regs[w_index] <= r_data;
    end
  end

  // Out-of-range and non-read cycles return zero.
  always_comb begin
    PRDATA1 = 32'd0;
    if (w_rd_en) begin
      PRDATA1 = r_regs[w_index];
    end
  end

endmodule

// File: tb/tb_apb_pair.sv
// Scoreboard bench for apb_pair: stimulus pushes expected ACCESS responses,
// a negedge monitor pops and compares on every PREADY cycle.
`timescale 1ns / 1ps

module tb_apb_pair;

  logic        PCLK;
  logic        PRESET;
  logic        PSEL;
  logic        transfer;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PDATA;
  logic        PENABLE;
  logic [31:0] PRWADDR;
  logic [31:0] PRWDATA;
  logic [31:0] PRDATA1;
  logic        PREADY;

  apb_pair dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PSEL    (PSEL),
    .transfer(transfer),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PDATA   (PDATA),
    .PENABLE (PENABLE),
    .PRWADDR (PRWADDR),
    .PRWDATA (PRWDATA),
    .PRDATA1 (PRDATA1),
    .PREADY  (PREADY)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem [16];
  int          total = 0;
  int          bad = 0;
  logic        mon_en = 1'b0;

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every PREADY cycle is one completed access.
  always @(negedge PCLK) begin
    if (mon_en && PRESET) begin
      if (PREADY) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pready: got addr %h expected no access", PRWADDR);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("access_penable", {31'd0, PENABLE}, 32'd1);
          check("access_addr", PRWADDR, e.addr);
          check("access_rdata", PRDATA1, e.rdata);
        end
      end else begin
        check("idle_rdata", PRDATA1, 32'd0);
      end
    end
  end

  function automatic logic in_range(input logic [31:0] a);
    return a[31:6] == 26'd0;
  endfunction

  // One request held for ncyc cycles (3 or 4 gives exactly one completed access).
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input int ncyc);
    exp_t e;
    e.addr  = a;
    e.rdata = (!w && in_range(a)) ? mem[a[5:2]] : 32'd0;
    exp_q.push_back(e);
    if (w && in_range(a)) mem[a[5:2]] = d;
    PSEL = 1'b1;
    transfer = 1'b1;
    PWRITE = w;
    PADDR = a;
    PDATA = d;
    repeat (ncyc) @(posedge PCLK);
    #1;
    PSEL = 1'b0;
    transfer = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;
  endtask

  logic [31:0] wa [4];
  logic [31:0] wd [4];

  initial begin
    wa[0] = 32'h0; wa[1] = 32'h4; wa[2] = 32'h8; wa[3] = 32'hC;
    wd[0] = 32'h00000309; wd[1] = 32'h07122023; wd[2] = 32'h4D4F544F; wd[3] = 32'h4D415849;
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    PRESET = 1'b0;
    PSEL = 1'b0;
    transfer = 1'b0;
    PWRITE = 1'b0;
    PADDR = 32'd0;
    PDATA = 32'd0;
    @(posedge PCLK);
    #1;
    check("rst_penable", {31'd0, PENABLE}, 32'd0);
    check("rst_pready", {31'd0, PREADY}, 32'd0);
    check("rst_prwaddr", PRWADDR, 32'd0);
    check("rst_prwdata", PRWDATA, 32'd0);
    check("rst_prdata1", PRDATA1, 32'd0);
    PRESET = 1'b1;
    mon_en = 1'b1;
    @(posedge PCLK);
    #1;

    for (int i = 0; i < 4; i++) xfer(1'b1, wa[i], wd[i], 4);
    for (int i = 0; i < 4; i++) xfer(1'b0, wa[i], 32'd0, 4);

    // Abort: PSEL dropped during SETUP.
    PSEL = 1'b1; transfer = 1'b1; PWRITE = 1'b1; PADDR = 32'h10; PDATA = 32'hDEADBEEF;
    @(posedge PCLK);
    #1;
    PSEL = 1'b0;
    transfer = 1'b0;
    @(posedge PCLK);
    #1;
    check("abort_penable", {31'd0, PENABLE}, 32'd0);
    @(posedge PCLK);
    #1;
    check("abort_penable2", {31'd0, PENABLE}, 32'd0);
    xfer(1'b0, 32'h10, 32'd0, 3);

    // Out-of-range write still completes but is dropped.
    xfer(1'b1, 32'h40, 32'h12345678, 3);
    xfer(1'b0, 32'h40, 32'd0, 3);
    xfer(1'b0, 32'h00, 32'd0, 3);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic        w;
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      xfer(w, a, $urandom, int'($urandom_range(3, 4)));
    end

    // Reset asserted in the middle of an ACCESS cycle.
    PSEL = 1'b1; transfer = 1'b1; PWRITE = 1'b1; PADDR = 32'h4; PDATA = 32'hCAFEF00D;
    repeat (2) @(posedge PCLK);
    #1;
    check("mid_penable_before", {31'd0, PENABLE}, 32'd1);
    PRESET = 1'b0;
    #1;
    check("mid_penable_after", {31'd0, PENABLE}, 32'd0);
    check("mid_pready_after", {31'd0, PREADY}, 32'd0);
    check("mid_prwaddr_after", PRWADDR, 32'd0);
    check("mid_prwdata_after", PRWDATA, 32'd0);
    PSEL = 1'b0;
    transfer = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    @(posedge PCLK);
    #1;
    PRESET = 1'b1;
    @(posedge PCLK);
    #1;
    for (int i = 0; i < 4; i++) xfer(1'b0, wa[i], 32'd0, 3);

    repeat (2) @(posedge PCLK);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
